// File: rtl/battle_turn_ctrl.sv
// Turn sequencer for the battle datapath: alternates player and wild attacks,
// pacing each HP-update select so it spans exactly one frame-tick register update.
module battle_turn_ctrl #(
    parameter int DELAY_FRAMES = 30,
    parameter int TURN_W       = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_tick,
    input  logic              start_battle,
    input  logic              attack_btn,
    input  logic              result_ack,
    input  logic              battle_done,
    input  logic [5:0]        hp_user,
    input  logic [5:0]        hp_wild,
    output logic              init_reg,
    output logic              wild_poke_reg,
    output logic              hp1_mux,
    output logic              hp2_mux,
    output logic              battle_active,
    output logic              user_won,
    output logic [TURN_W-1:0] turn_count,
    output logic [2:0]        state_dbg
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD   = 4'd1,
        P_WAIT = 4'd2,
        P_HIT  = 4'd3,
        P_CHK  = 4'd4,
        E_WAIT = 4'd5,
        E_HIT  = 4'd6,
        E_CHK  = 4'd7,
        DONE   = 4'd8
    } state_t;

    localparam logic [7:0] DLY_LOAD = 8'(DELAY_FRAMES - 1);

    state_t            state_q, state_d;
    logic [7:0]        dly_q, dly_d;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic              won_q, won_d;
    logic              first_done_q, first_done_d;
    logic              atk_q;
    logic              rise;
    logic              wild_q, hp1_q, hp2_q, active_q;
    logic [2:0]        dbg_q;

    assign rise = attack_btn & ~atk_q;

    always_comb begin
        state_d      = state_q;
        dly_d        = dly_q;
        turn_d       = turn_q;
        won_d        = won_q;
        first_done_d = first_done_q;
        unique case (state_q)
            IDLE: if (start_battle) begin
                state_d = LOAD;
                turn_d  = '0;
            end
            LOAD:   if (frame_tick) state_d = P_WAIT;
            P_WAIT: if (rise) state_d = P_HIT;
            P_HIT: if (frame_tick) begin
                state_d = P_CHK;
                if (turn_q != '1) turn_d = turn_q + TURN_W'(1);
            end
            P_CHK: begin
                if (battle_done || hp_wild == 6'd0) begin
                    won_d   = (hp_wild == 6'd0);
                    state_d = DONE;
                end else begin
                    dly_d   = DLY_LOAD;
                    state_d = E_WAIT;
                end
            end
            E_WAIT: if (frame_tick) begin
                if (dly_q == 8'd0) state_d = E_HIT;
                else               dly_d   = dly_q - 8'd1;
            end
            E_HIT: if (frame_tick) state_d = E_CHK;
            E_CHK: begin
                // Wild HP at zero wins even when both sides faint together.
                if (battle_done || hp_user == 6'd0) begin
                    won_d   = (hp_wild == 6'd0);
                    state_d = DONE;
                end else begin
                    state_d = P_WAIT;
                end
            end
            DONE: if (result_ack) begin
                state_d = IDLE;
                won_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == DONE) first_done_d = 1'b1;
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            dly_q        <= '0;
            turn_q       <= '0;
            won_q        <= 1'b0;
            first_done_q <= 1'b0;
            atk_q        <= 1'b0;
            wild_q       <= 1'b0;
            hp1_q        <= 1'b0;
            hp2_q        <= 1'b0;
            active_q     <= 1'b0;
            dbg_q        <= 3'd0;
        end else begin
            state_q      <= state_d;
            dly_q        <= dly_d;
            turn_q       <= turn_d;
            won_q        <= won_d;
            first_done_q <= first_done_d;
            atk_q        <= attack_btn;
            wild_q       <= (state_d != IDLE) && (state_d != LOAD);
            hp1_q        <= (state_d == E_HIT);
            hp2_q        <= (state_d == P_HIT);
            active_q     <= (state_d != IDLE) && (state_d != DONE);
            dbg_q        <= (state_d == DONE) ? 3'd7 : state_d[2:0];
        end
    end

    assign init_reg      = first_done_q;
    assign wild_poke_reg = wild_q;
    assign hp1_mux       = hp1_q;
    assign hp2_mux       = hp2_q;
    assign battle_active = active_q;
    assign user_won      = won_q;
    assign turn_count    = turn_q;
    assign state_dbg     = dbg_q;

endmodule
